// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals: bus access modes,
// UART register offsets and transmitter FSM encodings.
package mmio_pkg;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // A divisor below 2 cannot time a bit, so writes are clamped.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by a memory-mapped responder.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [15:0] memAddr;
  logic [31:0] writeMemData;
  logic [31:0] readData;
  logic        sel;

  modport master (output MemWrite, MemMode, memAddr, writeMemData,
                  input  readData, sel);
  modport slave  (input  MemWrite, MemMode, memAddr, writeMemData,
                  output readData, sel);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; push when full is dropped unless
// a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO plus 8N1 serialiser.
// Define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   off;
  logic [3:0]    reg_off;
  logic          in_win;
  logic          wr;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          irq_en;
  logic [15:0]   divisor;
  logic          busy;
  logic          unused_bits;

  logic [2:0]  state,    state_nx;
  logic [15:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_cnt,  bit_cnt_nx;
  logic [7:0]  shreg,    shreg_nx;
  logic        txd_nx;

  // Address decode: word-aligned offsets inside a 12-byte window.
  always_comb begin
    off     = bus.memAddr - BASE_ADDR;
    in_win  = (bus.memAddr >= BASE_ADDR) && (off <= 16'hB);
    reg_off = {off[3:2], 2'b00};
    wr      = bus.MemWrite && in_win;
    push    = wr && (reg_off == UART_TXDATA);
    busy    = (state != S_IDLE);
  end

  assign bus.sel     = in_win;
  assign unused_bits = ^{bus.MemMode, bus.writeMemData[31:16], off[15:4], off[1:0]};

  always_comb begin
    bus.readData = '0;
    if (in_win) begin
      case (reg_off)
        UART_STATUS: bus.readData = {24'b0, 4'(count), irq_en, busy, empty, full};
        UART_BAUD:   bus.readData = {16'b0, divisor};
        default:     bus.readData = '0;
      endcase
    end
  end

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.writeMemData[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Control registers and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en  <= 1'b0;
      divisor <= DIV_RESET;
      irq     <= 1'b0;
    end else begin
      if (wr && (reg_off == UART_STATUS)) irq_en  <= bus.writeMemData[3];
      if (wr && (reg_off == UART_BAUD))   divisor <= clamp_div(bus.writeMemData[15:0]);
      irq <= empty && irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      txd      <= txd_nx;
    end
  end

  // Next-state logic; txd is registered from the value of the state being entered.
  // The divisor is sampled only when a bit starts, so mid-frame writes wait a bit.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    txd_nx      = txd;
    pop         = 1'b0;

    if (state == S_IDLE) begin
      txd_nx = 1'b1;
      if (!empty) begin
        pop         = 1'b1;
        shreg_nx    = fifo_dout;
        state_nx    = S_START;
        baud_cnt_nx = divisor - 16'd1;
        txd_nx      = 1'b0;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt_nx = baud_cnt - 16'd1;
    end else begin
      baud_cnt_nx = divisor - 16'd1;
      case (state)
        S_START: begin
          state_nx   = S_DATA;
          bit_cnt_nx = '0;
          txd_nx     = shreg[0];
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = S_PARITY;
            txd_nx   = ^shreg;
`else
            state_nx = S_STOP;
            txd_nx   = 1'b1;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
            txd_nx     = shreg[bit_cnt + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_nx = S_STOP;
          txd_nx   = 1'b1;
        end
`endif
        S_STOP: begin
          if (!empty) begin
            pop      = 1'b1;
            shreg_nx = fifo_dout;
            state_nx = S_START;
            txd_nx   = 1'b0;
          end else begin
            state_nx = S_IDLE;
            txd_nx   = 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          txd_nx   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register table plus frame-level sequences.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_TX = 16'hFF00;
  localparam logic [15:0] A_ST = 16'hFF04;
  localparam logic [15:0] A_BD = 16'hFF08;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk;
  logic reset;
  logic txd;
  logic irq;
  int   checks;
  int   failures;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  mode;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] tx_bytes [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.memAddr      = a;
    bus.writeMemData = d;
    bus.MemWrite     = 1'b1;
    tick();
    bus.MemWrite     = 1'b0;
    bus.memAddr      = A_ST;
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [31:0] d);
    bus.memAddr = a;
    #1;
    d = bus.readData;
    bus.memAddr = A_ST;
  endtask

  // Called at the first sample of the start bit; returns at the first sample after stop.
  task automatic check_frame(input logic [7:0] d, input int div, input bit chk_busy);
    logic [10:0] bits;
    logic        got;
    logic        busy_bad;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^d, d, 1'b0};
`else
    bits = {1'b0, 1'b1, d, 1'b0};
`endif
    busy_bad = 1'b0;
    for (int b = 0; b < NB; b++) begin
      got = bits[b];
      for (int c = 0; c < div; c++) begin
        if (txd !== bits[b]) got = txd;
        if (chk_busy && bus.readData[2] !== 1'b1) busy_bad = 1'b1;
        tick();
      end
      check($sformatf("frame_%02h_bit%0d", d, b), 32'(got), 32'(bits[b]));
    end
    if (chk_busy) check($sformatf("frame_%02h_busy", d), 32'(busy_bad), 32'd0);
  endtask

  logic [31:0] rd;
  logic        done;
  logic        bad;

  initial begin
    checks   = 0;
    failures = 0;
    reset            = 1'b1;
    bus.MemWrite     = 1'b0;
    bus.MemMode      = MODE_WORD;
    bus.memAddr      = A_ST;
    bus.writeMemData = '0;

    vecs[0]  = '{1'b0, A_ST,          MODE_WORD, 32'h0,         32'h02,   1'b1};
    vecs[1]  = '{1'b0, A_BD,          MODE_WORD, 32'h0,         32'd868,  1'b1};
    vecs[2]  = '{1'b0, A_TX,          MODE_WORD, 32'h0,         32'h0,    1'b1};
    vecs[3]  = '{1'b0, BASE + 16'hC,  MODE_WORD, 32'h0,         32'h0,    1'b0};
    vecs[4]  = '{1'b0, BASE - 16'h1,  MODE_WORD, 32'h0,         32'h0,    1'b0};
    vecs[5]  = '{1'b1, A_BD,          MODE_WORD, 32'h0,         32'h2,    1'b1};
    vecs[6]  = '{1'b1, A_BD,          MODE_BYTE, 32'h1,         32'h2,    1'b1};
    vecs[7]  = '{1'b1, A_BD,          MODE_WORD, 32'h3,         32'h3,    1'b1};
    vecs[8]  = '{1'b1, A_BD,          MODE_WORD, 32'hDEAD1234,  32'h1234, 1'b1};
    vecs[9]  = '{1'b0, BASE + 16'hB,  MODE_BYTE, 32'h0,         32'h1234, 1'b1};
    vecs[10] = '{1'b1, A_ST,          MODE_HALF, 32'hFF,        32'h0A,   1'b1};
    vecs[11] = '{1'b1, A_ST + 16'h2,  MODE_BYTE, 32'h00,        32'h02,   1'b1};
    vecs[12] = '{1'b1, BASE + 16'hA,  MODE_BYTE, 32'h4,         32'h4,    1'b1};

    tx_bytes = '{8'hA1, 8'h5A, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h96, 8'h69, 8'hC3, 8'hEE};

    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);

    // Register access table
    for (int i = 0; i < 13; i++) begin
      bus.MemMode      = vecs[i].mode;
      bus.memAddr      = vecs[i].addr;
      bus.writeMemData = vecs[i].wdata;
      if (vecs[i].we) begin
        bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
      end
      #1;
      check($sformatf("vec%0d_rd", i), bus.readData, vecs[i].exp_rd);
      check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
      bus.memAddr = A_ST;
    end
    bus.MemMode = MODE_WORD;

    // Single frames at divisor 4
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h55);
    check("txd_high_before_pop", 32'(txd), 32'd1);
    tick();
    check_frame(8'h55, 4, 1'b1);
    bus_write(A_TX, 32'h07);
    tick();
    check_frame(8'h07, 4, 1'b1);
    read_reg(A_ST, rd);
    check("idle_status_after_frames", rd, 32'h02);
    check("idle_txd_after_frames", 32'(txd), 32'd1);

    // Burst of 10 pushes at divisor 2, then a push aligned with a pop while full
    bus_write(A_BD, 32'd2);
    fork
      begin
        bus.memAddr  = A_TX;
        bus.MemWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
          bus.writeMemData = 32'(tx_bytes[i]);
          tick();
        end
        bus.MemWrite = 1'b0;
        read_reg(A_ST, rd);
        check("burst_full_status", rd, 32'h85);
        repeat (2 * NB - 9) tick();
        bus.memAddr      = A_TX;
        bus.writeMemData = 32'h3C;
        bus.MemWrite     = 1'b1;
        tick();
        bus.MemWrite     = 1'b0;
        read_reg(A_ST, rd);
        check("push_pop_full_status", rd, 32'h85);
      end
      begin
        tick();
        tick();
        for (int i = 0; i < 9; i++) check_frame(tx_bytes[i], 2, 1'b0);
        check_frame(8'h3C, 2, 1'b0);
      end
    join
    read_reg(A_ST, rd);
    check("burst_idle_status", rd, 32'h02);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (txd !== 1'b1) bad = 1'b1;
      tick();
    end
    check("burst_no_extra_frame", 32'(bad), 32'd0);

    // Interrupt on FIFO empty
    bus_write(A_ST, 32'h8);
    check("irq_latency_0", 32'(irq), 32'd0);
    tick();
    check("irq_empty_enabled", 32'(irq), 32'd1);
    bus_write(A_TX, 32'hA5);
    check("irq_after_push_edge", 32'(irq), 32'd1);
    tick();
    check("irq_while_nonempty", 32'(irq), 32'd0);
    tick();
    check("irq_after_pop_empty", 32'(irq), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      read_reg(A_ST, rd);
      if (rd[2] == 1'b0) done = 1'b1;
    end
    check("irq_frame_completes", 32'(done), 32'd1);
    bus_write(A_ST, 32'h0);
    tick();
    check("irq_disabled", 32'(irq), 32'd0);

    // Reset in the middle of the data bits, with a second byte queued
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h07);
    bus_write(A_TX, 32'hA5);
    repeat (17) tick();
    check("mid_data_bit3_low", 32'(txd), 32'd0);
    read_reg(A_ST, rd);
    check("mid_data_status", rd, 32'h14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_irq", 32'(irq), 32'd0);
    read_reg(A_ST, rd);
    check("rst_mid_status", rd, 32'h02);
    read_reg(A_BD, rd);
    check("rst_mid_baud", rd, 32'd868);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (txd !== 1'b1) bad = 1'b1;
      tick();
    end
    check("rst_no_further_bits", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
